nd_wrr_arb_4to1: RTL and testbench
==================================

Name: nd_wrr_arb_4to1

Overview:
- Weighted round-robin arbiter that merges four 4-phase req/ack input channels onto one output channel.
- Sits in front of a shared node, e.g. a 2-to-1 merge node or its downstream link.
- Moves one message per grant: the selected input's message is captured into a holding register and forwarded.
- Input ack and output req are handshaked concurrently.
- Fairness is per-input credit bursts with rotating priority.

Parameters:
- ASZ, `NS_ADDRESS_SIZE, address field width.
- DSZ, `NS_DATA_SIZE, data field width.
- RSZ, `NS_REDUN_SIZE, redundancy field width.
- WGT, 2, maximum consecutive grants to one input while others wait (legal range 1..15).
- SYNC, 2, synchronizer depth on every incoming req/ack (legal range 1..3).

Ports:
- gch_clk  in  1  clock
- gch_reset  in  1  asynchronous, active-high reset
- gch_ready  out  1  high when out of reset and initialised
- rcv_addr  in  4*ASZ  input address fields, lane i at [i*ASZ +: ASZ]
- rcv_dat  in  4*DSZ  input data fields
- rcv_red  in  4*RSZ  input redundancy fields
- rcv_req  in  4  per-input request
- rcv_ack_out  out  4  per-input acknowledge
- snd0_addr  out  ASZ  output address
- snd0_dat  out  DSZ  output data
- snd0_red  out  RSZ  output redundancy
- snd0_req_out  out  1  output request
- snd0_ack  in  1  output acknowledge
- grant_id  out  2  index of the last granted input
- busy  out  1  high while a transfer is open

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs 0, snd0 message register 0, synchronizer flops 0.
  - State ARB, owner=3, credit=0.
  - gch_ready rises on the first gch_clk rising edge after reset deasserts.
- Synchronizers: rcv_req[i] and snd0_ack each pass through SYNC flops; the FSM sees only the synchronized versions (s_req, s_ack).
- A lane is eligible when s_req[i]=1 and rcv_ack_out[i]=0.
- State ARB: on an edge where any lane is eligible:
  - If lane owner is eligible and credit<WGT, pick owner and do credit+=1.
  - Otherwise pick the first eligible lane scanning owner+1, owner+2, ... (mod 4), set owner=pick and credit=1.
  - Same edge: capture the picked lane's addr/dat/red into snd0_*, set rcv_ack_out[pick]=1, snd0_req_out=1, grant_id=pick, busy=1.
  - Go to XFER.
- State XFER: the input half and output half close independently.
  - Input half: when s_req[pick]=0, clear rcv_ack_out[pick]; in_done=1.
  - Output half: when s_ack=1 while snd0_req_out=1, clear snd0_req_out. When s_ack=0 with req already cleared, out_done=1.
  - When in_done and out_done are both 1: clear both, busy=0, return to ARB.
  - ARB may regrant on the following edge, not the same edge.
- snd0_* hold stable from capture until the next capture. They never change while snd0_req_out=1.
- Latency with SYNC=2: rcv_req rising before edge E1 gives rcv_ack_out and snd0_req_out high after E3.
- Credit never exceeds WGT. WGT=1 degenerates to plain round robin.
- A lane whose ack is still high (input side not yet returned low) is ineligible. There is no double capture.
- If a requester drops req before it is granted, it is simply not selected; no error is raised.
- Reset mid-transfer: everything is aborted immediately with no partial output. After release the arbiter starts from owner=3, so lane 0 has first priority.
- gch_reset asserted for a single cycle must fully reinitialise the block.

Test Plan:
- Single lane, no contention: reset; lane 2 req with addr=0x5, dat=0xA5. Required: ack2 and snd0_req_out high 3 edges later; snd0_addr=0x5, snd0_dat=0xA5; grant_id=2; busy falls after both handshakes close.
- All four lanes requesting continuously, WGT=2, sink acks immediately. Grant order is 0,0,1,1,2,2,3,3,0,...; no lane exceeds 2 consecutive grants.
- WGT=1, lanes 1 and 3 requesting. Grants alternate 1,3,1,3.
- Slow sink: snd0_ack delayed 20 cycles while input 0 finishes early. rcv_ack_out[0] drops first; snd0_* stay stable; busy stays 1 until ack low; no new grant occurs.
- Reset mid-transfer (snd0_req_out=1): all outputs go 0 within the reset cycle with no clock edge needed. After release, lane 0 is granted first when lanes 0 and 3 both request.
- Lane that keeps req high after ack: it is not regranted until it lowers and re-raises req; other lanes are granted in between.

Source files
------------

// File: rtl/nd_wrr_arb_4to1_if.sv
// nd_wrr_arb_4to1_if: bundle of the four 4-phase input lanes and the single output lane.
// Signals: rcv_addr/dat/red/req in, rcv_ack_out back; snd0_addr/dat/red/req_out out, snd0_ack back.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

interface nd_wrr_arb_4to1_if #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
);
    logic [4*ASZ-1:0] rcv_addr;
    logic [4*DSZ-1:0] rcv_dat;
    logic [4*RSZ-1:0] rcv_red;
    logic [3:0]       rcv_req;
    logic [3:0]       rcv_ack_out;
    logic [ASZ-1:0]   snd0_addr;
    logic [DSZ-1:0]   snd0_dat;
    logic [RSZ-1:0]   snd0_red;
    logic             snd0_req_out;
    logic             snd0_ack;

    modport master (
        input  rcv_addr, rcv_dat, rcv_red, rcv_req, snd0_ack,
        output rcv_ack_out, snd0_addr, snd0_dat, snd0_red,
        output snd0_req_out
    );

    modport slave (
        output rcv_addr, rcv_dat, rcv_red, rcv_req, snd0_ack,
        input  rcv_ack_out, snd0_addr, snd0_dat, snd0_red,
        input  snd0_req_out
    );
endinterface

// File: rtl/nd_wrr_arb_4to1.sv
// nd_wrr_arb_4to1: weighted round-robin merge of four 4-phase lanes onto one.
// Ports: gch_clk, gch_reset (async, high), gch_ready, bus (master), grant_id, busy.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_wrr_arb_4to1 #(
    parameter int ASZ  = `NS_ADDRESS_SIZE,
    parameter int DSZ  = `NS_DATA_SIZE,
    parameter int RSZ  = `NS_REDUN_SIZE,
    parameter int WGT  = 2,
    parameter int SYNC = 2
) (
    input  logic               gch_clk,
    input  logic               gch_reset,
    output logic               gch_ready,
    nd_wrr_arb_4to1_if.master  bus,
    output logic [1:0]         grant_id,
    output logic               busy
);
    typedef enum logic {ARB, XFER} state_t;

    state_t         state_q, state_d;
    logic [3:0]     req_sync [SYNC];
    logic           ack_sync [SYNC];
    logic [3:0]     s_req;
    logic           s_ack;
    logic [3:0]     elig;

    logic [1:0]     owner_q, owner_d;
    logic [3:0]     credit_q, credit_d;
    logic [3:0]     ack_q, ack_d;
    logic           sreq_q, sreq_d;
    logic           in_q, in_d;
    logic           out_q, out_d;
    logic [1:0]     gid_q, gid_d;
    logic           busy_q, busy_d;
    logic           ready_q;
    logic [ASZ-1:0] addr_q, addr_d;
    logic [DSZ-1:0] dat_q, dat_d;
    logic [RSZ-1:0] red_q, red_d;
    logic [1:0]     pick;
    logic [1:0]     cand;

    assign s_req = req_sync[SYNC-1];
    assign s_ack = ack_sync[SYNC-1];
    assign elig  = s_req & ~ack_q;

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            for (int k = 0; k < SYNC; k++) begin
                req_sync[k] <= '0;
                ack_sync[k] <= 1'b0;
            end
        end else begin
            req_sync[0] <= bus.rcv_req;
            ack_sync[0] <= bus.snd0_ack;
            for (int k = 1; k < SYNC; k++) begin
                req_sync[k] <= req_sync[k-1];
                ack_sync[k] <= ack_sync[k-1];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        credit_d = credit_q;
        ack_d    = ack_q;
        sreq_d   = sreq_q;
        in_d     = in_q;
        out_d    = out_q;
        gid_d    = gid_q;
        busy_d   = busy_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        red_d    = red_q;
        pick     = owner_q;
        cand     = 2'd0;
        unique case (state_q)
            ARB: begin
                if (|elig) begin
                    // credit==0 means no burst is open, so the reset
                    // owner (3) does not get a free first grant.
                    if (credit_q != 4'd0 && credit_q < 4'(WGT)
                        && elig[owner_q]) begin
                        pick     = owner_q;
                        credit_d = credit_q + 4'd1;
                    end else begin
                        // Descending so the nearest lane after owner
                        // wins; k=4 wraps back to owner itself.
                        for (int k = 4; k >= 1; k--) begin
                            cand = owner_q + 2'(k);
                            if (elig[cand]) pick = cand;
                        end
                        owner_d  = pick;
                        credit_d = 4'd1;
                    end
                    addr_d      = bus.rcv_addr[int'(pick)*ASZ +: ASZ];
                    dat_d       = bus.rcv_dat[int'(pick)*DSZ +: DSZ];
                    red_d       = bus.rcv_red[int'(pick)*RSZ +: RSZ];
                    ack_d[pick] = 1'b1;
                    sreq_d      = 1'b1;
                    gid_d       = pick;
                    busy_d      = 1'b1;
                    in_d        = 1'b0;
                    out_d       = 1'b0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (!s_req[gid_q]) begin
                    ack_d[gid_q] = 1'b0;
                    in_d         = 1'b1;
                end
                if (sreq_q && s_ack) sreq_d = 1'b0;
                if (!sreq_q && !s_ack) out_d = 1'b1;
                if (in_q && out_q) begin
                    in_d    = 1'b0;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ARB;
                end
            end
        endcase
    end

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            state_q  <= ARB;
            owner_q  <= 2'd3;
            credit_q <= 4'd0;
            ack_q    <= 4'd0;
            sreq_q   <= 1'b0;
            in_q     <= 1'b0;
            out_q    <= 1'b0;
            gid_q    <= 2'd0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            addr_q   <= '0;
            dat_q    <= '0;
            red_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            ack_q    <= ack_d;
            sreq_q   <= sreq_d;
            in_q     <= in_d;
            out_q    <= out_d;
            gid_q    <= gid_d;
            busy_q   <= busy_d;
            ready_q  <= 1'b1;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            red_q    <= red_d;
        end
    end

    assign gch_ready        = ready_q;
    assign grant_id         = gid_q;
    assign busy             = busy_q;
    assign bus.rcv_ack_out  = ack_q;
    assign bus.snd0_req_out = sreq_q;
    assign bus.snd0_addr    = addr_q;
    assign bus.snd0_dat     = dat_q;
    assign bus.snd0_red     = red_q;
endmodule

// File: tb/tb_nd_wrr_arb_4to1.sv
// tb_nd_wrr_arb_4to1: directed bench for the weighted round-robin arbiter.
// Two instances (WGT=2, WGT=1) share clock and reset.
module tb_nd_wrr_arb_4to1;
  localparam int ASZ = 8;
  localparam int DSZ = 8;
  localparam int RSZ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nd_wrr_arb_4to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) b2 ();
  nd_wrr_arb_4to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) b1 ();

  logic rdy_2, rdy_1, bsy_2, bsy_1;
  logic [1:0] gid_2, gid_1;

  nd_wrr_arb_4to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
    .WGT(2), .SYNC(2)) dut2 (
    .gch_clk(clk), .gch_reset(rst), .gch_ready(rdy_2),
    .bus(b2.master), .grant_id(gid_2), .busy(bsy_2));

  nd_wrr_arb_4to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
    .WGT(1), .SYNC(2)) dut1 (
    .gch_clk(clk), .gch_reset(rst), .gch_ready(rdy_1),
    .bus(b1.master), .grant_id(gid_1), .busy(bsy_1));

  logic [3:0] req [2];
  logic sack [2];
  logic [ASZ-1:0] av [2][4];
  logic [DSZ-1:0] dv [2][4];
  logic [RSZ-1:0] rv [2][4];

  logic [3:0] ack_o [2];
  logic sreq_o [2];
  logic [ASZ-1:0] sa_o [2];
  logic [DSZ-1:0] sd_o [2];
  logic rdy [2];
  logic bsy [2];
  logic [1:0] gid [2];

  assign b2.rcv_req = req[0];
  assign b1.rcv_req = req[1];
  assign b2.snd0_ack = sack[0];
  assign b1.snd0_ack = sack[1];
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign b2.rcv_addr[g*ASZ +: ASZ] = av[0][g];
    assign b2.rcv_dat[g*DSZ +: DSZ] = dv[0][g];
    assign b2.rcv_red[g*RSZ +: RSZ] = rv[0][g];
    assign b1.rcv_addr[g*ASZ +: ASZ] = av[1][g];
    assign b1.rcv_dat[g*DSZ +: DSZ] = dv[1][g];
    assign b1.rcv_red[g*RSZ +: RSZ] = rv[1][g];
  end
  assign ack_o[0] = b2.rcv_ack_out;
  assign ack_o[1] = b1.rcv_ack_out;
  assign sreq_o[0] = b2.snd0_req_out;
  assign sreq_o[1] = b1.snd0_req_out;
  assign sa_o[0] = b2.snd0_addr;
  assign sa_o[1] = b1.snd0_addr;
  assign sd_o[0] = b2.snd0_dat;
  assign sd_o[1] = b1.snd0_dat;
  assign rdy[0] = rdy_2;
  assign rdy[1] = rdy_1;
  assign bsy[0] = bsy_2;
  assign bsy[1] = bsy_1;
  assign gid[0] = gid_2;
  assign gid[1] = gid_1;

  typedef struct {
    logic [1:0] id;
    logic [ASZ-1:0] a;
    logic [DSZ-1:0] d;
  } gr_t;

  typedef struct {
    string nm;
    int d;
    logic [3:0] mask;
    int n;
    logic [1:0] seq [10];
  } vec_t;

  gr_t gq0 [$];
  gr_t gq1 [$];
  bit src_en [2][4];
  bit auto_snk [2];
  logic prev_sreq [2];
  int pass_n = 0;
  int tot_n = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? gq0.size() : gq1.size();
  endfunction

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (sreq_o[d] && !prev_sreq[d]) begin
        gr_t g;
        g.id = gid[d];
        g.a = sa_o[d];
        g.d = sd_o[d];
        if (d == 0) gq0.push_back(g);
        else gq1.push_back(g);
      end
      prev_sreq[d] = sreq_o[d];
      for (int i = 0; i < 4; i++) begin
        if (src_en[d][i]) begin
          if (req[d][i] && ack_o[d][i]) req[d][i] = 1'b0;
          else if (!req[d][i] && !ack_o[d][i]) req[d][i] = 1'b1;
        end
      end
      if (auto_snk[d]) sack[d] = sreq_o[d];
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      req[d] = 4'd0;
      sack[d] = 1'b0;
      auto_snk[d] = 1'b0;
      prev_sreq[d] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        src_en[d][i] = 1'b0;
        av[d][i] = 8'(8'h10 + i);
        dv[d][i] = 8'(8'hA0 + i);
        rv[d][i] = 4'(i + 5);
      end
    end
    gq0.delete();
    gq1.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vt [4];
  logic [31:0] sa_k, sd_k;
  bit ok;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0].nm = "wgt2_all4"; vt[0].d = 0; vt[0].mask = 4'hf;
    vt[0].n = 10;
    vt[0].seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                  2'd3, 2'd3, 2'd0, 2'd0};
    vt[1].nm = "wgt1_l13"; vt[1].d = 1; vt[1].mask = 4'b1010;
    vt[1].n = 4;
    vt[1].seq = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd0,
                  2'd0, 2'd0, 2'd0, 2'd0};
    vt[2].nm = "wgt2_l02"; vt[2].d = 0; vt[2].mask = 4'b0101;
    vt[2].n = 5;
    vt[2].seq = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0,
                  2'd0, 2'd0, 2'd0, 2'd0};
    vt[3].nm = "wgt1_all4"; vt[3].d = 1; vt[3].mask = 4'hf;
    vt[3].n = 5;
    vt[3].seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0,
                  2'd0, 2'd0, 2'd0, 2'd0};

    clear_inputs();
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(rdy[0]), 0);
    check("rst_ack", 32'(ack_o[0]), 0);
    check("rst_sreq", 32'(sreq_o[0]), 0);
    check("rst_busy", 32'(bsy[0]), 0);
    check("rst_gid", 32'(gid[0]), 0);
    check("rst_addr", 32'(sa_o[0]), 0);
    check("rst_ready1", 32'(rdy[1]), 0);
    rst = 1'b0;
    step();
    check("ready_rise", 32'(rdy[0]), 1);
    check("ready_rise1", 32'(rdy[1]), 1);

    av[0][2] = 8'h05;
    dv[0][2] = 8'hA5;
    req[0][2] = 1'b1;
    step();
    step();
    check("lat_e2_ack", 32'(ack_o[0]), 0);
    step();
    check("lat_e3_ack", 32'(ack_o[0]), 32'h4);
    check("lat_e3_sreq", 32'(sreq_o[0]), 1);
    check("single_addr", 32'(sa_o[0]), 32'h05);
    check("single_dat", 32'(sd_o[0]), 32'hA5);
    check("single_gid", 32'(gid[0]), 2);
    check("single_busy", 32'(bsy[0]), 1);
    req[0][2] = 1'b0;
    sack[0] = 1'b1;
    for (int n = 0; n < 20 && sreq_o[0]; n++) step();
    check("single_sreq_low", 32'(sreq_o[0]), 0);
    check("single_busy_hold", 32'(bsy[0]), 1);
    sack[0] = 1'b0;
    for (int n = 0; n < 20 && bsy[0]; n++) step();
    check("single_busy_low", 32'(bsy[0]), 0);
    check("single_ack_low", 32'(ack_o[0]), 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      auto_snk[vt[v].d] = 1'b1;
      for (int i = 0; i < 4; i++) src_en[vt[v].d][i] = vt[v].mask[i];
      for (int c = 0; c < 3000 && qsize(vt[v].d) < vt[v].n; c++)
        step();
      check({vt[v].nm, "_count"}, 32'(qsize(vt[v].d) >= vt[v].n), 1);
      for (int k = 0; k < vt[v].n && k < qsize(vt[v].d); k++) begin
        gr_t g;
        logic [1:0] e;
        e = vt[v].seq[k];
        g = (vt[v].d == 0) ? gq0[k] : gq1[k];
        check($sformatf("%s_id%0d", vt[v].nm, k), 32'(g.id), 32'(e));
        check($sformatf("%s_ad%0d", vt[v].nm, k), 32'(g.a),
              32'(av[vt[v].d][e]));
      end
    end

    do_reset();
    req[0][0] = 1'b1;
    for (int n = 0; n < 20 && !ack_o[0][0]; n++) step();
    check("slow_grant0", 32'(ack_o[0]), 32'h1);
    req[0][0] = 1'b0;
    req[0][1] = 1'b1;
    sa_k = 32'(sa_o[0]);
    sd_k = 32'(sd_o[0]);
    ok = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (32'(sa_o[0]) != sa_k || 32'(sd_o[0]) != sd_k) ok = 1'b0;
      if (!sreq_o[0] || !bsy[0] || ack_o[0][1] || gid[0] != 2'd0)
        ok = 1'b0;
    end
    check("slow_stable", 32'(ok), 1);
    check("slow_in_first", 32'(ack_o[0][0]), 0);
    check("slow_sreq_hold", 32'(sreq_o[0]), 1);
    sack[0] = 1'b1;
    for (int n = 0; n < 20 && sreq_o[0]; n++) step();
    check("slow_sreq_low", 32'(sreq_o[0]), 0);
    check("slow_busy_hold", 32'(bsy[0]), 1);
    sack[0] = 1'b0;
    for (int n = 0; n < 20 && bsy[0]; n++) step();
    check("slow_busy_low", 32'(bsy[0]), 0);
    for (int n = 0; n < 20 && !ack_o[0][1]; n++) step();
    check("slow_next_gid", 32'(gid[0]), 1);
    check("slow_next_addr", 32'(sa_o[0]), 32'h11);

    do_reset();
    req[0][1] = 1'b1;
    for (int n = 0; n < 20 && !sreq_o[0]; n++) step();
    check("mid_pre_sreq", 32'(sreq_o[0]), 1);
    check("mid_pre_gid", 32'(gid[0]), 1);
    #1 rst = 1'b1;
    #1;
    check("mid_sreq", 32'(sreq_o[0]), 0);
    check("mid_ack", 32'(ack_o[0]), 0);
    check("mid_busy", 32'(bsy[0]), 0);
    check("mid_gid", 32'(gid[0]), 0);
    check("mid_addr", 32'(sa_o[0]), 0);
    check("mid_dat", 32'(sd_o[0]), 0);
    check("mid_ready", 32'(rdy[0]), 0);
    req[0] = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req[0] = 4'b1001;
    for (int n = 0; n < 20 && ack_o[0] == 4'd0; n++) step();
    check("post_rst_ack", 32'(ack_o[0]), 32'h1);
    check("post_rst_gid", 32'(gid[0]), 0);

    do_reset();
    auto_snk[1] = 1'b1;
    req[1] = 4'b0011;
    for (int n = 0; n < 20 && ack_o[1] == 4'd0; n++) step();
    check("hold_first", 32'(ack_o[1]), 32'h1);
    ok = 1'b1;
    for (int n = 0; n < 30; n++) begin
      step();
      if (ack_o[1] != 4'b0001 || !bsy[1]) ok = 1'b0;
    end
    check("hold_no_regrant", 32'(ok), 1);
    req[1][0] = 1'b0;
    for (int n = 0; n < 20 && ack_o[1][0]; n++) step();
    check("hold_ack0_low", 32'(ack_o[1][0]), 0);
    req[1][0] = 1'b1;
    for (int n = 0; n < 40 && !ack_o[1][1]; n++) step();
    check("hold_other_gid", 32'(gid[1]), 1);
    check("hold_other_ack", 32'(ack_o[1]), 32'h2);
    req[1][1] = 1'b0;
    for (int n = 0; n < 40 && !ack_o[1][0]; n++) step();
    check("hold_regrant_gid", 32'(gid[1]), 0);
    check("hold_regrant_ack", 32'(ack_o[1]), 32'h1);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
